// File: rtl/bsg_sdr_link_tag_driver.sv
// bsg_sdr_link_tag_driver
//
// Serial bsg_tag packet transmitter for the SDR link pearl's tag clients.
// It accepts one parallel packet request at a time over ready/valid and
// shifts it out LSB-first on tag_data_o. Packet framing:
//   start(1) | node_id (id_width_lp) | data_not_reset (1) | len (lg_width_p) | payload (len)
//
// Ports:
//   clk_i            clock, also forwarded externally as the tag clock
//   reset_i          asynchronous active-high reset
//   v_i              packet request valid
//   node_id_i        destination client id
//   data_not_reset_i 1 = data packet, 0 = client reset packet
//   len_i            number of payload bits
//   payload_i        payload, bits at index >= len_i ignored
//   ready_and_o      request accepted when v_i & ready_and_o
//   tag_data_o       serial tag line (registered)
//   busy_o           high whenever the FSM is not idle
//
// Build option: define BSG_SDR_LINK_TAG_DRIVER_IDLE_GAP_EN to insert four
// zero cycles (GAP state) after every packet; otherwise packets may run
// back to back with no idle bit between them.
module bsg_sdr_link_tag_driver #(
  parameter int els_p      = 4,
  parameter int lg_width_p = 3
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         v_i,
  input  logic [((els_p > 1) ? $clog2(els_p) : 1)-1:0] node_id_i,
  input  logic                                         data_not_reset_i,
  input  logic [lg_width_p-1:0]                        len_i,
  input  logic [((1 << lg_width_p) - 1)-1:0]           payload_i,
  output logic                                         ready_and_o,
  output logic                                         tag_data_o,
  output logic                                         busy_o
);

  localparam int id_width_lp          = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int max_payload_width_lp = (1 << lg_width_p) - 1;
  localparam int cnt_width_lp         = (id_width_lp > lg_width_p + 1) ? id_width_lp : lg_width_p + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ID,
    S_DNR,
    S_LEN,
`ifdef BSG_SDR_LINK_TAG_DRIVER_IDLE_GAP_EN
    S_PAYLOAD,
    S_GAP
`else
    S_PAYLOAD
`endif
  } state_e;

  state_e                          state_q, state_d;
  logic [cnt_width_lp-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                            tag_q, tag_d;
  logic                            ready_q, ready_d;
  logic                            busy_q, busy_d;

  logic [id_width_lp-1:0]          id_q, id_d, id_sh;
  logic                            dnr_q, dnr_d;
  logic [lg_width_p-1:0]           len_q, len_d, len_sh;
  logic [max_payload_width_lp-1:0] pay_q, pay_d, pay_sh;

  logic hs;
  logic eop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = 1'b0;
    id_d    = id_q;
    dnr_d   = dnr_q;
    len_d   = len_q;
    pay_d   = pay_q;
    eop     = 1'b0;
    hs      = v_i & ready_q;
    cnt_inc = cnt_q + cnt_width_lp'(1);
    // Next bit of each field is selected by shifting with the advanced count.
    id_sh   = id_q >> cnt_inc;
    len_sh  = len_q >> cnt_inc;
    pay_sh  = pay_q >> cnt_inc;

    // ready is only high in IDLE or on a packet's last bit, so a handshake
    // always means the request fields can be captured right now.
    if (hs) begin
      id_d  = node_id_i;
      dnr_d = data_not_reset_i;
      len_d = len_i;
      pay_d = payload_i;
    end

    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d = S_START;
          cnt_d   = '0;
          tag_d   = 1'b1;
        end
      end
      S_START: begin
        state_d = S_ID;
        cnt_d   = '0;
        tag_d   = id_q[0];
      end
      S_ID: begin
        if (cnt_q == cnt_width_lp'(id_width_lp - 1)) begin
          state_d = S_DNR;
          cnt_d   = '0;
          tag_d   = dnr_q;
        end else begin
          cnt_d = cnt_inc;
          tag_d = id_sh[0];
        end
      end
      S_DNR: begin
        state_d = S_LEN;
        cnt_d   = '0;
        tag_d   = len_q[0];
      end
      S_LEN: begin
        if (cnt_q == cnt_width_lp'(lg_width_p - 1)) begin
          if (len_q != '0) begin
            state_d = S_PAYLOAD;
            cnt_d   = '0;
            tag_d   = pay_q[0];
          end else begin
            eop = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          tag_d = len_sh[0];
        end
      end
      S_PAYLOAD: begin
        if (cnt_inc == cnt_width_lp'(len_q)) begin
          eop = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          tag_d = pay_sh[0];
        end
      end
`ifdef BSG_SDR_LINK_TAG_DRIVER_IDLE_GAP_EN
      S_GAP: begin
        if (cnt_q == cnt_width_lp'(3)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (eop) begin
`ifdef BSG_SDR_LINK_TAG_DRIVER_IDLE_GAP_EN
      state_d = S_GAP;
      cnt_d   = '0;
      tag_d   = 1'b0;
`else
      // A request taken on the final bit starts immediately with no idle bit.
      cnt_d = '0;
      if (hs) begin
        state_d = S_START;
        tag_d   = 1'b1;
      end else begin
        state_d = S_IDLE;
        tag_d   = 1'b0;
      end
`endif
    end

    busy_d = (state_d != S_IDLE);
`ifdef BSG_SDR_LINK_TAG_DRIVER_IDLE_GAP_EN
    ready_d = (state_d == S_IDLE);
`else
    // Registered look-ahead: ready rises in the cycle that drives the final bit.
    ready_d = (state_d == S_IDLE)
            || ((state_d == S_LEN) && (cnt_d == cnt_width_lp'(lg_width_p - 1)) && (len_d == '0))
            || ((state_d == S_PAYLOAD) && ((cnt_d + cnt_width_lp'(1)) == cnt_width_lp'(len_d)));
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tag_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Request fields are only meaningful while the FSM is active, so no reset.
  always_ff @(posedge clk_i) begin
    id_q  <= id_d;
    dnr_q <= dnr_d;
    len_q <= len_d;
    pay_q <= pay_d;
  end

  assign ready_and_o = ready_q;
  assign tag_data_o  = tag_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_bsg_sdr_link_tag_driver.sv
module tb_bsg_sdr_link_tag_driver;

  localparam int ELS = 4;
  localparam int LGW = 3;
  localparam int IDW = 2;
  localparam int PW  = (1 << LGW) - 1;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           v_i;
  logic [IDW-1:0] node_id_i;
  logic           data_not_reset_i;
  logic [LGW-1:0] len_i;
  logic [PW-1:0]  payload_i;
  logic           ready_and_o;
  logic           tag_data_o;
  logic           busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_q[$];

  bsg_sdr_link_tag_driver #(.els_p(ELS), .lg_width_p(LGW)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .v_i             (v_i),
    .node_id_i       (node_id_i),
    .data_not_reset_i(data_not_reset_i),
    .len_i           (len_i),
    .payload_i       (payload_i),
    .ready_and_o     (ready_and_o),
    .tag_data_o      (tag_data_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the packet as a list of serial bits.
  task automatic build_packet(input int id, input int dnr, input int len, input int pay);
    exp_q.delete();
    exp_q.push_back(1'b1);
    for (int i = 0; i < IDW; i++) exp_q.push_back(((id >> i) & 1) != 0);
    exp_q.push_back(dnr != 0);
    for (int i = 0; i < LGW; i++) exp_q.push_back(((len >> i) & 1) != 0);
    for (int i = 0; i < len; i++) exp_q.push_back(((pay >> i) & 1) != 0);
  endtask

  task automatic scramble_inputs();
    node_id_i        = IDW'($urandom);
    data_not_reset_i = 1'($urandom);
    len_i            = LGW'($urandom);
    payload_i        = PW'($urandom);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Send one packet and check every serial bit plus the return to idle.
  task automatic test_packet(input string name, input int id, input int dnr, input int len, input int pay);
    int w;
    w = 0;
    while (ready_and_o !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    n_tests++;
    if (ready_and_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: ready=%0b required 1", name, ready_and_o);
    end
    build_packet(id, dnr, len, pay);
    v_i              = 1'b1;
    node_id_i        = IDW'(id);
    data_not_reset_i = 1'(dnr);
    len_i            = LGW'(len);
    payload_i        = PW'(pay);
    step();
    v_i = 1'b0;
    scramble_inputs();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (tag_data_o !== exp_q[i] || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s bit%0d: tag=%0b busy=%0b required tag=%0b busy=1", name, i, tag_data_o, busy_o, exp_q[i]);
      end
`ifndef BSG_SDR_LINK_TAG_DRIVER_IDLE_GAP_EN
      n_tests++;
      if (ready_and_o !== (i == exp_q.size() - 1)) begin
        n_fail++;
        $display("FAIL %s ready_bit%0d: ready=%0b required %0b", name, i, ready_and_o, (i == exp_q.size() - 1));
      end
`endif
      step();
    end
`ifdef BSG_SDR_LINK_TAG_DRIVER_IDLE_GAP_EN
    for (int g = 0; g < 4; g++) begin
      n_tests++;
      if (tag_data_o !== 1'b0 || ready_and_o !== 1'b0 || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s gap%0d: tag=%0b ready=%0b busy=%0b required 0 0 1", name, g, tag_data_o, ready_and_o, busy_o);
      end
      step();
    end
`endif
    n_tests++;
    if (tag_data_o !== 1'b0 || busy_o !== 1'b0 || ready_and_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_after: tag=%0b busy=%0b ready=%0b required 0 0 1", name, tag_data_o, busy_o, ready_and_o);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    v_i     = 1'b0;
    scramble_inputs();
    #2;
    n_tests++;
    if (tag_data_o !== 1'b0 || busy_o !== 1'b0 || ready_and_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: tag=%0b busy=%0b ready=%0b required 0 0 1", tag_data_o, busy_o, ready_and_o);
    end
    step();
    step();
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_idle_hold();
    v_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      scramble_inputs();
      n_tests++;
      if (tag_data_o !== 1'b0 || busy_o !== 1'b0 || ready_and_o !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_hold cyc%0d: tag=%0b busy=%0b ready=%0b required 0 0 1", i, tag_data_o, busy_o, ready_and_o);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    build_packet(1, 1, 1, 1);
    v_i              = 1'b1;
    node_id_i        = 2'd1;
    data_not_reset_i = 1'b1;
    len_i            = 3'd1;
    payload_i        = 7'd1;
    step();
    for (int pkt = 0; pkt < 2; pkt++) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (pkt == 1 && i == 0) v_i = 1'b0;
        n_tests++;
        if (tag_data_o !== exp_q[i] || busy_o !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b pkt%0d bit%0d: tag=%0b busy=%0b required tag=%0b busy=1", pkt, i, tag_data_o, busy_o, exp_q[i]);
        end
`ifndef BSG_SDR_LINK_TAG_DRIVER_IDLE_GAP_EN
        n_tests++;
        if (ready_and_o !== (i == exp_q.size() - 1)) begin
          n_fail++;
          $display("FAIL b2b_ready pkt%0d bit%0d: ready=%0b required %0b", pkt, i, ready_and_o, (i == exp_q.size() - 1));
        end
`endif
        step();
      end
`ifdef BSG_SDR_LINK_TAG_DRIVER_IDLE_GAP_EN
      for (int g = 0; g < 4; g++) begin
        n_tests++;
        if (tag_data_o !== 1'b0 || ready_and_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_gap pkt%0d cyc%0d: tag=%0b ready=%0b required 0 0", pkt, g, tag_data_o, ready_and_o);
        end
        step();
      end
      if (pkt == 0) begin
        n_tests++;
        if (tag_data_o !== 1'b0 || ready_and_o !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_idle: tag=%0b ready=%0b required 0 1", tag_data_o, ready_and_o);
        end
        step();
      end
`endif
    end
    n_tests++;
    if (tag_data_o !== 1'b0 || busy_o !== 1'b0 || ready_and_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_end: tag=%0b busy=%0b ready=%0b required 0 0 1", tag_data_o, busy_o, ready_and_o);
    end
  endtask

  task automatic test_reset_mid_packet();
    v_i              = 1'b1;
    node_id_i        = 2'd2;
    data_not_reset_i = 1'b1;
    len_i            = 3'd3;
    payload_i        = 7'b0000101;
    step();
    v_i = 1'b0;
    // Advance to bit index 5, which lies in the length field.
    for (int i = 0; i < 5; i++) step();
    #2;
    reset_i = 1'b1;
    #1;
    n_tests++;
    if (tag_data_o !== 1'b0 || busy_o !== 1'b0 || ready_and_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: tag=%0b busy=%0b ready=%0b required 0 0 1", tag_data_o, busy_o, ready_and_o);
    end
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (tag_data_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_residual cyc%0d: tag=%0b busy=%0b required 0 0", i, tag_data_o, busy_o);
      end
      step();
    end
    test_packet("after_reset", 2, 1, 3, 5);
  endtask

  task automatic test_random();
    int id, dnr, len, pay, gap;
    for (int n = 0; n < 30; n++) begin
      id  = $urandom_range(ELS - 1, 0);
      dnr = $urandom_range(1, 0);
      len = $urandom_range(PW, 0);
      pay = $urandom_range((1 << PW) - 1, 0);
      gap = $urandom_range(3, 0);
      test_packet("random", id, dnr, len, pay);
      for (int g = 0; g < gap; g++) begin
        step();
        n_tests++;
        if (tag_data_o !== 1'b0 || busy_o !== 1'b0) begin
          n_fail++;
          $display("FAIL random_idle pkt%0d: tag=%0b busy=%0b required 0 0", n, tag_data_o, busy_o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_packet("basic", 2, 1, 3, 5);
    step();
    test_packet("zero_len", 3, 0, 0, 0);
    step();
    test_back_to_back();
    step();
    test_reset_mid_packet();
    step();
    test_packet("max_payload", 1, 1, 7, 7'b1100101);
    step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
